int_scheduler: RTL
==================

Name: int_scheduler

Overview:
- Sequences the 16 interrupt sources of the BrainForge8 core into a single serviced stream for the CPU.
- Captures rising edges into a pending register and applies a configurable enable mask.
- Picks one winner by fixed or round-robin priority and presents it through a NEXT_ID/NEXT_ON/ACK/EOI handshake.
- Sits between the raw trigger sources (EXT0-3, DMA, stack, SFT, IRQ0) and the CPU control unit.

Parameters:
- NUM_SRC, 16, number of interrupt sources; IDs 0..NUM_SRC-1, ID width 4.
- RSTB_ID, 8, ID that is non-maskable and always wins arbitration.
- SFT_BASE, 9, ID of the first software trigger; six consecutive IDs.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- SRC  in  16  raw source levels; bit i maps to ID i.
- CFG_WE  in  1  configuration write strobe, one cycle.
- CFG_ADDR  in  2  register select: 0=MASK_LO, 1=MASK_HI, 2=SOFT_TRIG, 3=CTRL.
- CFG_WDATA  in  8  write data.
- NEXT_ID  out  4  presented / in-service interrupt ID.
- NEXT_ON  out  1  an interrupt is being presented.
- IRQ  out  1  CPU interrupt request; equals NEXT_ON.
- ACK  in  1  CPU accepts the presented interrupt.
- EOI  in  1  CPU finished servicing.
- BUSY  out  1  an interrupt is in service.
- LOST  out  1  sticky flag: an edge arrived on an already-pending source.

Behaviour:
- Reset:
  - pending=0, mask=16'h0000, CTRL=0 (GEN=0, RR=0), SRC_Q=0, last_id=0.
  - state=IDLE, NEXT_ID=0, NEXT_ON=0, IRQ=0, BUSY=0, LOST=0.
- Edge capture:
  - pending[i] sets on any cycle with SRC[i]=1 and SRC_Q[i]=0; SRC_Q<=SRC every cycle.
  - SOFT_TRIG write sets pending[SFT_BASE+k] for each CFG_WDATA[k]=1, k=0..5.
- LOST: sets when a new edge or soft trigger targets a bit that is already pending. It clears only on a CTRL write with CFG_WDATA[7]=1.
- Simultaneous set and clear of the same pending bit: set wins.
- Config registers:
  - MASK_LO/HI write mask[7:0]/mask[15:8].
  - CTRL: bit0=GEN (global enable), bit1=RR (round-robin), bit7=LOST clear.
- Eligibility: eligible = pending & mask when GEN=1, else 0. pending[RSTB_ID] is always eligible regardless of mask and GEN.
- Arbitration (combinational over the eligible vector):
  - RSTB_ID always wins.
  - RR=0: lowest ID wins.
  - RR=1: search starts at last_id+1 and wraps modulo 16.
- FSM, four states:
  - IDLE: if any bit is eligible, go to ARB.
  - ARB: register the winner into NEXT_ID, go to PRESENT. If nothing is eligible any longer, return to IDLE.
  - PRESENT: NEXT_ON=IRQ=1.
    - On ACK: clear pending[NEXT_ID], last_id<=NEXT_ID, NEXT_ON<=0, BUSY<=1, go to SVC.
    - Mask or GEN changes here do not withdraw the presentation.
  - SVC: NEXT_ID holds. On EOI: BUSY<=0, go to IDLE.
- Latency: a source edge sampled at edge n sets pending at n. ARB follows at n+1, NEXT_ON rises at n+2, so the response is 2 cycles from IDLE.
- ACK outside PRESENT and EOI outside SVC are ignored.
- No nesting: new edges during SVC only accumulate in pending.
- RST asserted in any state returns to the reset values on the next edge; in-flight pending interrupts are discarded.

Decomposition:
- Package int_pkg holds:
  - the INT_ID_* constants (EXT0=0 .. IRQ0=15);
  - the state enum IDLE/ARB/PRESENT/SVC;
  - CFG address constants and CTRL bit positions.
- One sub-module, int_prio_pick: combinational. Inputs: 16-bit eligible vector, rr flag, last_id. Outputs: winner ID and valid.

Test Plan:
- Mask=16'hFFFF, GEN=1, pulse SRC[3] -> NEXT_ON=1, NEXT_ID=3 two cycles later. ACK -> BUSY=1, NEXT_ON=0. EOI -> IDLE, pending[3]=0.
- Edges on SRC[5] and SRC[2] in the same cycle, RR=0 -> ID 2 is served first, then ID 5 after EOI.
- RR=1, sources 1 and 4 repeatedly re-pended -> service order 1,4,1,4.
- GEN=0, mask=0, pulse SRC[8] and SRC[0] -> only ID 8 is presented; ID 0 stays pending until GEN=1.
- SOFT_TRIG write 8'h21 -> pending bits 9 and 14 set; served 9 then 14. A second write with 8'h01 before ID 9 is served -> LOST=1. CTRL write of 8'h80 clears it.
- Assert RST during PRESENT with pending=16'h00F0 -> next cycle all outputs are 0, pending=0, state=IDLE.

Source files
------------

// File: rtl/int_scheduler_pkg.sv
// Shared definitions for the BrainForge8 interrupt scheduler:
// source IDs, sequencer states, configuration addresses and CTRL bits.
package int_pkg;

   localparam int NUM_SRC  = 16;
   localparam int ID_W     = 4;
   localparam int SFT_BASE = 9;
   localparam int SFT_NUM  = 6;

   localparam logic [ID_W-1:0] INT_ID_EXT0    = 4'd0;
   localparam logic [ID_W-1:0] INT_ID_EXT1    = 4'd1;
   localparam logic [ID_W-1:0] INT_ID_EXT2    = 4'd2;
   localparam logic [ID_W-1:0] INT_ID_EXT3    = 4'd3;
   localparam logic [ID_W-1:0] INT_ID_DMA     = 4'd4;
   localparam logic [ID_W-1:0] INT_ID_STK_OVF = 4'd5;
   localparam logic [ID_W-1:0] INT_ID_STK_UNF = 4'd6;
   localparam logic [ID_W-1:0] INT_ID_STK_ERR = 4'd7;
   localparam logic [ID_W-1:0] INT_ID_RSTB    = 4'd8;
   localparam logic [ID_W-1:0] INT_ID_SFT0    = 4'd9;
   localparam logic [ID_W-1:0] INT_ID_SFT1    = 4'd10;
   localparam logic [ID_W-1:0] INT_ID_SFT2    = 4'd11;
   localparam logic [ID_W-1:0] INT_ID_SFT3    = 4'd12;
   localparam logic [ID_W-1:0] INT_ID_SFT4    = 4'd13;
   localparam logic [ID_W-1:0] INT_ID_SFT5    = 4'd14;
   localparam logic [ID_W-1:0] INT_ID_IRQ0    = 4'd15;

   // Non-maskable source that always wins arbitration
   localparam logic [ID_W-1:0] RSTB_ID = INT_ID_RSTB;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARB     = 2'd1,
      ST_PRESENT = 2'd2,
      ST_SVC     = 2'd3
   } int_state_e;

   localparam logic [1:0] CFG_MASK_LO   = 2'd0;
   localparam logic [1:0] CFG_MASK_HI   = 2'd1;
   localparam logic [1:0] CFG_SOFT_TRIG = 2'd2;
   localparam logic [1:0] CFG_CTRL      = 2'd3;

   localparam int CTRL_GEN      = 0;
   localparam int CTRL_RR       = 1;
   localparam int CTRL_LOST_CLR = 7;

endpackage

// File: rtl/int_prio_pick.sv
// Combinational priority picker: the non-maskable source first, then either
// lowest ID or a round-robin search starting just after the last serviced ID.
module int_prio_pick
   import int_pkg::*;
(
   input  logic [NUM_SRC-1:0] elig,
   input  logic               rr,
   input  logic [ID_W-1:0]    last_id,
   output logic [ID_W-1:0]    win_id,
   output logic               win_vld
);

   // Scan from lowest to highest priority so the last hit is the winner
   always_comb begin
      logic [ID_W-1:0] idx;
      idx     = '0;
      win_id  = '0;
      win_vld = |elig;
      if (elig[RSTB_ID]) begin
         win_id = RSTB_ID;
      end else if (!rr) begin
         for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win_id = i[ID_W-1:0];
         end
      end else begin
         // k = NUM_SRC wraps to last_id itself, the lowest round-robin rank
         for (int k = NUM_SRC; k >= 1; k--) begin
            idx = last_id + k[ID_W-1:0];
            if (elig[idx]) win_id = idx;
         end
      end
   end

endmodule

// File: rtl/int_scheduler.sv
// Interrupt scheduler: captures source edges and software triggers into a
// pending register, masks them, picks one winner and walks it through the
// NEXT_ON/ACK/EOI handshake with the CPU control unit.
module int_scheduler
   import int_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_SRC-1:0] SRC,
   input  logic               CFG_WE,
   input  logic [1:0]         CFG_ADDR,
   input  logic [7:0]         CFG_WDATA,
   output logic [ID_W-1:0]    NEXT_ID,
   output logic               NEXT_ON,
   output logic               IRQ,
   input  logic               ACK,
   input  logic               EOI,
   output logic               BUSY,
   output logic               LOST
);

   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] soft_vec;
   logic [NUM_SRC-1:0] set_vec;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] eligible;
   logic               gen;
   logic               rr;
   logic [ID_W-1:0]    last_id;
   logic [ID_W-1:0]    win_id;
   logic               win_vld;
   int_state_e         state;

   // Per-cycle set/clear requests for pending and the eligible vector
   always_comb begin
      soft_vec = '0;
      if (CFG_WE && CFG_ADDR == CFG_SOFT_TRIG)
         soft_vec[SFT_BASE +: SFT_NUM] = CFG_WDATA[SFT_NUM-1:0];
      set_vec = (SRC & ~src_q) | soft_vec;
      clr_vec = '0;
      if (state == ST_PRESENT && ACK)
         clr_vec[NEXT_ID] = 1'b1;
      eligible = gen ? (pending & mask) : '0;
      eligible[RSTB_ID] = pending[RSTB_ID];
   end

   // Edge capture, pending/LOST bookkeeping and configuration registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending <= '0;
         mask    <= '0;
         gen     <= 1'b0;
         rr      <= 1'b0;
         src_q   <= '0;
         LOST    <= 1'b0;
      end else begin
         src_q   <= SRC;
         // A set in the same cycle as the ACK clear keeps the bit pending
         pending <= (pending & ~clr_vec) | set_vec;
         if (CFG_WE && CFG_ADDR == CFG_CTRL && CFG_WDATA[CTRL_LOST_CLR])
            LOST <= 1'b0;
         if (|(set_vec & pending))
            LOST <= 1'b1;
         if (CFG_WE) begin
            case (CFG_ADDR)
               CFG_MASK_LO: mask[7:0]  <= CFG_WDATA;
               CFG_MASK_HI: mask[15:8] <= CFG_WDATA;
               CFG_CTRL: begin
                  gen <= CFG_WDATA[CTRL_GEN];
                  rr  <= CFG_WDATA[CTRL_RR];
               end
               default: ;
            endcase
         end
      end
   end

   int_prio_pick u_pick (
      .elig    (eligible),
      .rr      (rr),
      .last_id (last_id),
      .win_id  (win_id),
      .win_vld (win_vld)
   );

   // Handshake sequencer: IDLE -> ARB -> PRESENT -> SVC -> IDLE
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         NEXT_ID <= '0;
         NEXT_ON <= 1'b0;
         BUSY    <= 1'b0;
         last_id <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|eligible) state <= ST_ARB;
            end
            ST_ARB: begin
               if (win_vld) begin
                  NEXT_ID <= win_id;
                  NEXT_ON <= 1'b1;
                  state   <= ST_PRESENT;
               end else begin
                  state   <= ST_IDLE;
               end
            end
            // Once presented, mask/GEN changes cannot withdraw the request
            ST_PRESENT: begin
               if (ACK) begin
                  last_id <= NEXT_ID;
                  NEXT_ON <= 1'b0;
                  BUSY    <= 1'b1;
                  state   <= ST_SVC;
               end
            end
            ST_SVC: begin
               if (EOI) begin
                  BUSY  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign IRQ = NEXT_ON;

endmodule
